// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the multicycle core: FSM states, opcodes, halt causes,
// ALU encoding, and the combinational alu/immgen/bru helpers.
package rv32_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] HC_NONE     = 2'd0;
  localparam logic [1:0] HC_ILLEGAL  = 2'd1;
  localparam logic [1:0] HC_MISALIGN = 2'd2;
  localparam logic [1:0] HC_ECALL    = 2'd3;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
    return y;
  endfunction

  // Non-ALU classes (loads, stores, jumps, LUI/AUIPC) all use the adder.
  function automatic alu_op_t alu_decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic f7b5);
    alu_op_t op;
    op = ALU_ADD;
    if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      case (f3)
        3'b000:  op = (opc == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] immgen(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OPC_STORE:          imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ir[31:12], 12'd0};
      OPC_JAL:            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:            imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

  function automatic logic bru(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multiciclo_fsm.sv
// Sequencer for the multicycle core (FETCH/DECODE/EXEC/MEM/WB/HALT); 1 cycle per state.
// mem_req is held in FETCH/MEM until mem_ready, so any number of wait states is absorbed.
module multiciclo_fsm
  import rv32_pkg::*;
#(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   mem_ready,
  input  logic   legal,
  input  logic   is_branch,
  input  logic   is_ldst,
  input  logic   is_store,
  input  logic   is_system,
  input  logic   misaligned,
  output state_t state,
  output logic   mem_req,
  output logic   mem_hs,
  output logic   retire
);

  state_t state_nxt;
  logic   run;

  // run keeps the bus quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (mem_hs) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if (is_branch)      state_nxt = ST_FETCH;
        else if (is_ldst)   state_nxt = misaligned ? ST_HALT : ST_MEM;
        else if (is_system) state_nxt = HALT_ON_ECALL ? ST_HALT : ST_FETCH;
        else                state_nxt = ST_WB;
      end
      ST_MEM:    if (mem_hs) state_nxt = is_store ? ST_FETCH : ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req = run && (state == ST_FETCH || state == ST_MEM);
    mem_hs  = mem_req && mem_ready;
    retire  = (state == ST_WB)
            || (state == ST_EXEC && is_branch)
            || (state == ST_MEM && is_store && mem_hs);
  end

endmodule

// File: rtl/multiciclo.sv
// Multicycle RV32I core on one shared valid/ready memory port; branch 3, ALU/JAL/store 4,
// load 5 cycles at zero wait; each memory wait state stalls the FSM by one cycle.
module multiciclo
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic [2:0]  state_out
);

  state_t      state;
  logic        mem_hs;
  logic [31:0] pc, ir, a_q, b_q, imm_q, ea_q, res_q;
  logic [31:0] rf [32];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic        is_op_imm, is_op, is_system, is_ldst, legal;
  logic [31:0] op_a, op_b, alu_y, br_tgt, pc_inc, lane, load_val, st_data;
  logic [3:0]  st_strb;
  logic        taken, misaligned;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_op_imm = (opc == OPC_OP_IMM);
  assign is_op     = (opc == OPC_OP);
  assign is_system = (opc == OPC_SYSTEM);
  assign is_ldst   = is_load | is_store;
  assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_ldst
                   | is_op_imm | is_op | is_system;

  assign op_a   = is_auipc ? pc : (is_lui ? 32'd0 : a_q);
  assign op_b   = is_op ? b_q : imm_q;
  assign alu_y  = alu(alu_decode(opc, f3, ir[30]), op_a, op_b);
  assign br_tgt = pc + imm_q;
  assign pc_inc = pc + 32'd4;
  assign taken  = bru(f3, a_q, b_q);
  assign misaligned = (f3[1:0] == 2'b01 && alu_y[0]) || (f3[1] && alu_y[1:0] != 2'b00);

  always_comb begin
    lane = mem_rdata >> {ea_q[1:0], 3'b000};
    case (f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ea_q[1:0];
        st_data = {4{b_q[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << ea_q[1:0];
        st_data = {2{b_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = b_q;
      end
    endcase
  end

  // MEM is only ever entered by loads/stores, so EA drives the bus there.
  assign mem_we    = (state == ST_MEM) && is_store;
  assign mem_addr  = (state == ST_MEM) ? {ea_q[31:2], 2'b00} : {pc[31:2], 2'b00};
  assign mem_wdata = mem_we ? st_data : 32'd0;
  assign mem_wstrb = mem_we ? st_strb : 4'd0;

  assign halted    = (state == ST_HALT);
  assign pc_out    = pc;
  assign inst_out  = ir;
  assign state_out = state;

  multiciclo_fsm #(
    .HALT_ON_ECALL(HALT_ON_ECALL)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .legal      (legal),
    .is_branch  (is_branch),
    .is_ldst    (is_ldst),
    .is_store   (is_store),
    .is_system  (is_system),
    .misaligned (misaligned),
    .state      (state),
    .mem_req    (mem_req),
    .mem_hs     (mem_hs),
    .retire     (retire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_VECTOR;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      ea_q       <= '0;
      res_q      <= '0;
      instret    <= '0;
      halt_cause <= HC_NONE;
    end else begin
      if (retire) instret <= instret + 32'd1;
      case (state)
        ST_FETCH: if (mem_hs) ir <= mem_rdata;
        ST_DECODE: begin
          a_q   <= rf[rs1];
          b_q   <= rf[rs2];
          imm_q <= immgen(ir);
          if (!legal) halt_cause <= HC_ILLEGAL;
        end
        ST_EXEC: begin
          ea_q  <= alu_y;
          res_q <= alu_y;
          if (is_branch) pc <= taken ? br_tgt : pc_inc;
          if (is_jal) begin
            pc    <= br_tgt;
            res_q <= pc_inc;
          end
          if (is_jalr) begin
            pc    <= {alu_y[31:1], 1'b0};
            res_q <= pc_inc;
          end
          if (is_ldst && misaligned) halt_cause <= HC_MISALIGN;
          if (is_system) begin
            if (HALT_ON_ECALL) halt_cause <= HC_ECALL;
            else               pc <= pc_inc;
          end
        end
        ST_MEM: begin
          if (mem_hs) begin
            if (is_store) pc <= pc_inc;
            else          res_q <= load_val;
          end
        end
        ST_WB: if (!(is_jal || is_jalr)) pc <= pc_inc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == ST_WB && rd != 5'd0) begin
      rf[rd] <= res_q;
    end
  end

endmodule

// File: doc/multiciclo.md
# multiciclo

Multicycle RV32I core: the next-generation CPU top for this design. It replaces the separate instruction and data memories with one shared memory port using a valid/ready handshake, so it tolerates arbitrary memory wait states. It executes each instruction through a fixed state machine and reports retirement, halt cause and an instruction counter for the testbench.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
- HALT_ON_ECALL, 1, 1: ECALL/EBREAK halt the core; 0: treated as NOP

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = read (fetch or load)
- mem_addr  out  32  byte address, word-aligned (addr[1:0]=0 always)
- mem_wdata  out  32  store data, byte lanes replicated
- mem_wstrb  out  4  byte enables, 0 on reads
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  transfer completes in a cycle with mem_req=1 and mem_ready=1
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count, wraps at 2^32
- halted  out  1  core stopped
- halt_cause  out  2  0 none, 1 illegal opcode, 2 misaligned access, 3 ECALL/EBREAK
- pc_out  out  32  current PC
- inst_out  out  32  latched instruction register
- state_out  out  3  current FSM state encoding

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: issue a read at the PC. On handshake, latch mem_rdata into IR and go to DECODE.
- DECODE:
  - read rs1/rs2 into A/B holding registers, generate the immediate.
  - An illegal opcode (not one of the 9 RV32I base groups plus SYSTEM) causes HALT with cause 1.
- EXEC: ALU operation and branch compare; the destination depends on the instruction class.
  - Branch: PC ← taken ? PC+imm : PC+4, then FETCH.
  - JAL/JALR: PC ← target, with JALR target bit 0 cleared; save PC+4 for WB, then WB.
  - Load/store:
    - compute the effective address (EA).
    - A halfword access with EA[0]=1, or a word access with EA[1:0]≠0, causes HALT with cause 2. No memory request is issued.
    - Otherwise go to MEM.
  - ALU/LUI/AUIPC: go to WB.
  - ECALL/EBREAK: HALT with cause 3 if HALT_ON_ECALL, else PC+4 and FETCH.
- MEM: hold the request until handshake.
  - Load: extract byte/half using EA[1:0] and funct3, sign- or zero-extend, then WB.
  - Store: mem_wstrb is 0001<<EA[1:0] for SB, 0011<<EA[1:0] for SH, 1111 for SW. Data is replicated across lanes. PC ← PC+4, then FETCH.
- WB:
  - write rd (writes to x0 discarded).
  - PC ← PC+4, except JAL/JALR, which already updated PC.
  - Then FETCH.
- Retirement: retire pulses, and instret increments, in the cycle that leaves WB, in the store's MEM handshake cycle, and in the branch's EXEC cycle.
- HALT: no requests; outputs hold. Only reset exits HALT.

## Timing
- Handshake: while mem_req=1, mem_we/addr/wdata/wstrb stay stable until mem_ready. mem_ready with mem_req=0 is ignored. Zero-wait memory means mem_ready is asserted in the first request cycle.
- Zero-wait latencies: branch 3 cycles; ALU/JAL/store 4; load 5. Each wait state adds 1.
- Reset values (asynchronous, immediate): PC=RESET_VECTOR, state=FETCH, IR=0, x1–x31=0, instret=0, mem_req=0, retire=0, halted=0, halt_cause=0.
  - Reset asserted mid-transaction drops mem_req at once; the transaction is abandoned.
  - The first fetch request occurs in the first clk edge cycle after reset release.
- instret wraps FFFF_FFFF→0 with no side effects.

## Structure
- Package rv32_pkg:
  - state enum
  - opcode constants
  - halt_cause constants
  - ALU op encoding shared with the existing alu
- Reuses the existing alu, immgen and bru combinationally. Contains its own resettable 32×32 register file (2R/1W).
- One sub-module: multiciclo_fsm (state register, next-state logic, handshake control).

## Test plan
- Reset vector: RESET_VECTOR=32'h100, addi x1,x0,5 with zero-wait memory → first mem_addr=0x100; x1=5 after 4 cycles; instret=1.
- Wait states: mem_ready delayed 3 cycles on every request, running addi then lw → request signals stable throughout; lw completes in 5+6=11 cycles; loaded value correct.
- Byte/half lanes: sb x2(=0xAB) to 0x203 → wstrb=1000, wdata=0xABABABAB. Then lb from 0x203 → x3=0xFFFFFFAB; lbu → 0x000000AB.
- Branch/jump: beq taken with imm=-8 at PC 0x20 → next fetch at 0x18, 3 cycles. jalr x1,x5,3 with x5=0x40 → PC=0x42, x1=old PC+4.
- Faults: lw at 0x202 → halted=1, cause=2, no memory request. Opcode 7'h7F → cause=1. ECALL → cause=3. Outputs frozen until reset.
- Mid-transaction reset: reset asserted during a load's MEM wait → mem_req=0 that same cycle; after release, fetch at RESET_VECTOR with instret=0.
